// File: rtl/mem_port_if.sv
// Request/response bundle between the fetch/data ports, the arbiter and the memory.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface mem_port_if;
  logic        f_req_valid;
  logic [31:0] f_req_addr;
  logic        f_req_ready;
  logic        f_rsp_valid;
  logic [31:0] f_rsp_data;

  logic        d_req_valid;
  logic        d_req_we;
  logic [2:0]  d_req_funct3;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        d_misalign;

  logic        mem_en;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  f_req_valid, f_req_addr,
    output f_req_ready, f_rsp_valid, f_rsp_data,
    input  d_req_valid, d_req_we, d_req_funct3, d_req_addr, d_req_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_misalign,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output f_req_valid, f_req_addr,
    input  f_req_ready, f_rsp_valid, f_rsp_data,
    output d_req_valid, d_req_we, d_req_funct3, d_req_addr, d_req_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_misalign,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch and data requests, data-first with starvation guard.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned data accesses instead of aligning them down.
//
// state | meaning
// IDLE  | no read response due next cycle
// RD_F  | fetch read issued last cycle; f_rsp_valid high
// RD_D  | data load issued last cycle; d_rsp_valid high
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_port_if.slave bus
);
  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, RD_F, RD_D} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          fetch_wins, grant_f, grant_d;
  logic          is_byte, is_half, is_word, trap;
  logic [31:0]   d_addr;
  logic [1:0]    off;
  logic          unused_f_addr;

  assign unused_f_addr = ^bus.f_req_addr[1:0];

  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    if (bus.d_req_we) begin
      is_byte = (bus.d_req_funct3 == 3'b000);
      is_half = (bus.d_req_funct3 == 3'b001);
    end else begin
      is_byte = (bus.d_req_funct3[1:0] == 2'b00);
      is_half = (bus.d_req_funct3[1:0] == 2'b01);
    end
    is_word = !is_byte && !is_half;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign, misalign_q;

  assign misalign = (is_half && bus.d_req_addr[0]) ||
                    (is_word && (bus.d_req_addr[1:0] != 2'b00));
  assign trap     = misalign;
  assign d_addr   = bus.d_req_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= grant_d && misalign;
  end
  assign bus.d_misalign = misalign_q;
`else
  // Misaligned requests are silently pulled down to their natural alignment.
  assign trap   = 1'b0;
  assign d_addr = {bus.d_req_addr[31:2],
                   bus.d_req_addr[1] & ~is_word,
                   bus.d_req_addr[0] & ~is_word & ~is_half};
  assign bus.d_misalign = 1'b0;
`endif

  assign off = d_addr[1:0];

  always_comb begin
    fetch_wins    = bus.f_req_valid && (!bus.d_req_valid || (starve_cnt == LIMIT));
    grant_f       = rst_n && fetch_wins;
    grant_d       = rst_n && bus.d_req_valid && !fetch_wins;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 4'b0000;
    bus.mem_addr  = 30'd0;
    bus.mem_wdata = 32'd0;
    state_nxt     = IDLE;
    if (grant_f) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.f_req_addr[31:2];
      state_nxt    = RD_F;
    end else if (grant_d) begin
      bus.mem_en   = !trap;
      bus.mem_addr = d_addr[31:2];
      if (bus.d_req_we) begin
        if (!trap) begin
          if (is_byte) begin
            bus.mem_we    = 4'b0001 << off;
            bus.mem_wdata = {4{bus.d_req_wdata[7:0]}};
          end else if (is_half) begin
            bus.mem_we    = 4'b0011 << off;
            bus.mem_wdata = {2{bus.d_req_wdata[15:0]}};
          end else begin
            bus.mem_we    = 4'b1111;
            bus.mem_wdata = bus.d_req_wdata;
          end
        end
      end else if (!trap) begin
        state_nxt = RD_D;
      end
    end
  end

  assign bus.f_req_ready = grant_f;
  assign bus.d_req_ready = grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!bus.f_req_valid || grant_f) starve_cnt <= '0;
      else if (grant_d && (starve_cnt != LIMIT)) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Memory returns data the cycle after the strobe, so responses are pass-through.
  assign bus.f_rsp_valid = (state == RD_F);
  assign bus.d_rsp_valid = (state == RD_D);
  assign bus.f_rsp_data  = bus.mem_rdata;
  assign bus.d_rsp_data  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mem_port_if bus();

  mem_port_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.f_req_valid  = 1'b0;
    bus.f_req_addr   = 32'd0;
    bus.d_req_valid  = 1'b0;
    bus.d_req_we     = 1'b0;
    bus.d_req_funct3 = 3'b010;
    bus.d_req_addr   = 32'd0;
    bus.d_req_wdata  = 32'd0;
    bus.mem_rdata    = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic data_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bus.d_req_valid  = 1'b1;
    bus.d_req_we     = we;
    bus.d_req_funct3 = f3;
    bus.d_req_addr   = addr;
    bus.d_req_wdata  = wdata;
  endtask

  logic exp_f [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    bus.f_req_valid = 1'b1;
    bus.f_req_addr  = 32'h100;
    bus.d_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_f_ready", 32'(bus.f_req_ready), 32'd0);
    check("rst_d_ready", 32'(bus.d_req_ready), 32'd0);
    check("rst_mem_en",  32'(bus.mem_en),      32'd0);
    check("rst_f_rsp",   32'(bus.f_rsp_valid), 32'd0);
    check("rst_d_rsp",   32'(bus.d_rsp_valid), 32'd0);
    check("rst_misal",   32'(bus.d_misalign),  32'd0);

    next_cycle();
    rst_n = 1'b1;
    idle_inputs();

    // fetch 0x100 alone
    next_cycle();
    bus.f_req_valid = 1'b1;
    bus.f_req_addr  = 32'h100;
    @(negedge clk);
    check("fetch_ready",   32'(bus.f_req_ready), 32'd1);
    check("fetch_d_ready", 32'(bus.d_req_ready), 32'd0);
    check("fetch_mem_en",  32'(bus.mem_en),      32'd1);
    check("fetch_mem_we",  32'(bus.mem_we),      32'd0);
    check("fetch_addr",    32'(bus.mem_addr),    32'h40);
    next_cycle();
    idle_inputs();
    bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("fetch_rsp_v",   32'(bus.f_rsp_valid), 32'd1);
    check("fetch_rsp_d",   bus.f_rsp_data,       32'hDEADBEEF);
    check("fetch_d_rsp",   32'(bus.d_rsp_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("fetch_rsp_end", 32'(bus.f_rsp_valid), 32'd0);

    // SB 0x203
    next_cycle();
    data_req(1'b1, 3'b000, 32'h203, 32'h000000A5);
    @(negedge clk);
    check("sb_ready", 32'(bus.d_req_ready), 32'd1);
    check("sb_we",    32'(bus.mem_we),      32'b1000);
    check("sb_wdata", bus.mem_wdata,        32'hA5A5A5A5);
    check("sb_addr",  32'(bus.mem_addr),    32'h80);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("sb_no_rsp", 32'(bus.d_rsp_valid), 32'd0);
    check("sb_we_off", 32'(bus.mem_we),      32'd0);

    // SH 0x202 and unlisted store funct3 as SW
    data_req(1'b1, 3'b001, 32'h202, 32'h00001234);
    @(negedge clk);
    check("sh_we",    32'(bus.mem_we),   32'b1100);
    check("sh_wdata", bus.mem_wdata,     32'h12341234);
    next_cycle();
    data_req(1'b1, 3'b011, 32'h10, 32'hCAFEF00D);
    @(negedge clk);
    check("sx_we",    32'(bus.mem_we),   32'b1111);
    check("sx_wdata", bus.mem_wdata,     32'hCAFEF00D);
    check("sx_addr",  32'(bus.mem_addr), 32'h4);
    next_cycle();
    idle_inputs();

    // contention: expect D,D,D,F,D
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      bus.f_req_valid = 1'b1;
      bus.f_req_addr  = 32'h800;
      data_req(1'b1, 3'b010, 32'h700, 32'h1);
      @(negedge clk);
      check($sformatf("starve_f%0d", i), 32'(bus.f_req_ready), 32'(exp_f[i]));
      check($sformatf("starve_d%0d", i), 32'(bus.d_req_ready), 32'(!exp_f[i]));
    end
    next_cycle();
    idle_inputs();
    next_cycle();

    // LW 0x302
    data_req(1'b0, 3'b010, 32'h302, 32'd0);
    @(negedge clk);
    check("lw_ready", 32'(bus.d_req_ready), 32'd1);
`ifdef MEM_MISALIGN_TRAP_EN
    check("lw_mem_en", 32'(bus.mem_en), 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("lw_misal",  32'(bus.d_misalign),  32'd1);
    check("lw_no_rsp", 32'(bus.d_rsp_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("lw_misal_end", 32'(bus.d_misalign), 32'd0);
`else
    check("lw_mem_en", 32'(bus.mem_en),   32'd1);
    check("lw_addr",   32'(bus.mem_addr), 32'hC0);
    check("lw_we",     32'(bus.mem_we),   32'd0);
    next_cycle();
    idle_inputs();
    bus.mem_rdata = 32'h5A5A0001;
    @(negedge clk);
    check("lw_rsp_v", 32'(bus.d_rsp_valid), 32'd1);
    check("lw_rsp_d", bus.d_rsp_data,       32'h5A5A0001);
    check("lw_misal", 32'(bus.d_misalign),  32'd0);
    next_cycle();
`endif
    idle_inputs();

    // back-to-back load then fetch
    next_cycle();
    bus.f_req_valid = 1'b1;
    bus.f_req_addr  = 32'h500;
    data_req(1'b0, 3'b010, 32'h400, 32'd0);
    @(negedge clk);
    check("b2b_d_grant", 32'(bus.d_req_ready), 32'd1);
    check("b2b_addr0",   32'(bus.mem_addr),    32'h100);
    next_cycle();
    bus.d_req_valid = 1'b0;
    bus.mem_rdata   = 32'h11111111;
    @(negedge clk);
    check("b2b_f_grant", 32'(bus.f_req_ready), 32'd1);
    check("b2b_addr1",   32'(bus.mem_addr),    32'h140);
    check("b2b_d_rsp",   32'(bus.d_rsp_valid), 32'd1);
    check("b2b_d_data",  bus.d_rsp_data,       32'h11111111);
    check("b2b_f_rsp0",  32'(bus.f_rsp_valid), 32'd0);
    next_cycle();
    idle_inputs();
    bus.mem_rdata = 32'h22222222;
    @(negedge clk);
    check("b2b_f_rsp",   32'(bus.f_rsp_valid), 32'd1);
    check("b2b_f_data",  bus.f_rsp_data,       32'h22222222);
    check("b2b_d_rsp1",  32'(bus.d_rsp_valid), 32'd0);

    // reset right after a load grant
    next_cycle();
    idle_inputs();
    data_req(1'b0, 3'b010, 32'h600, 32'd0);
    @(negedge clk);
    check("rl_grant", 32'(bus.d_req_ready), 32'd1);
    next_cycle();
    rst_n = 1'b0;
    idle_inputs();
    bus.f_req_valid = 1'b1;
    bus.d_req_valid = 1'b1;
    @(negedge clk);
    check("rl_d_rsp",   32'(bus.d_rsp_valid), 32'd0);
    check("rl_f_ready", 32'(bus.f_req_ready), 32'd0);
    check("rl_d_ready", 32'(bus.d_req_ready), 32'd0);
    check("rl_mem_en",  32'(bus.mem_en),      32'd0);
    next_cycle();
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    check("rl_post_d", 32'(bus.d_rsp_valid), 32'd0);
    check("rl_post_f", 32'(bus.f_rsp_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("rl_post_d2", 32'(bus.d_rsp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: consecutive data grants allowed while fetch waits.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- f_req_valid  in  1  fetch request
- f_req_addr  in  32  fetch byte address, word-aligned
- f_req_ready  out  1  fetch request granted this cycle
- f_rsp_valid  out  1  fetch read data valid
- f_rsp_data  out  32  fetch read word
- d_req_valid  in  1  data request
- d_req_we  in  1  1 = store, 0 = load
- d_req_funct3  in  3  RISC-V load/store funct3
- d_req_addr  in  32  data byte address
- d_req_wdata  in  32  store data, right-justified
- d_req_ready  out  1  data request accepted this cycle
- d_rsp_valid  out  1  load word valid (raw word; lane extraction is downstream)
- d_rsp_data  out  32  load raw word
- d_misalign  out  1  misaligned-access pulse
- mem_en  out  1  memory access strobe
- mem_we  out  4  byte write enables
- mem_addr  out  30  word address (byte address [31:2])
- mem_wdata  out  32  lane-positioned write data
- mem_rdata  in  32  memory read data, valid one cycle after mem_en with mem_we=0

Function
REQ-003 At most one grant per cycle; f_req_ready and d_req_ready SHALL never be high together.
REQ-004 Default priority is data over fetch.
REQ-005 Starvation counter SHALL increment on each data grant while f_req_valid=1, and clear on a fetch grant or whenever f_req_valid=0.
REQ-006 When the counter equals STARVE_LIMIT, fetch SHALL win the next contended cycle.
REQ-007 Grant outputs (ready, mem_en, mem_we, mem_addr, mem_wdata) SHALL be combinational in the grant cycle G.
REQ-008 Read response timing: the read response valid SHALL be registered high at G+1, with *_rsp_data = mem_rdata; a new grant is allowed at G+1 (fully pipelined).
REQ-009 FSM SHALL have states IDLE, RD_F and RD_D, with these transitions:
- IDLE to RD_F on a fetch grant.
- IDLE to RD_D on a data-load grant.
- Any state back to IDLE on a cycle with no read grant.
- Back-to-back read grants retarget RD_F/RD_D directly.
REQ-010 Stores SHALL produce no response; mem_we nonzero only in the grant cycle.
REQ-011 Store lane placement by d_req_funct3, with off = d_req_addr[1:0]:
- SB (000): mem_we = 4'b0001 << off; byte replicated to all four lanes.
- SH (001): mem_we = 4'b0011 << off; halfword replicated to both halves.
- SW (010): mem_we = 4'b1111.
REQ-012 Loads SHALL drive mem_we = 0.
REQ-013 Unlisted funct3 on a store SHALL be treated as SW.
REQ-014 Misaligned access is defined as: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0.
REQ-015 d_rsp_valid and f_rsp_valid SHALL never both be high.

Reset
REQ-016 On rst_n low, asynchronously: state=IDLE, starvation counter=0, f_rsp_valid=0, d_rsp_valid=0, d_misalign=0.
REQ-017 Reset mid-read SHALL discard the pending response; no rsp_valid after reset release without a new grant.
REQ-018 While rst_n is low: both readies=0 and mem_en=0.

Configuration
REQ-019 With MEM_MISALIGN_TRAP_EN defined, a misaligned data request SHALL be accepted (d_req_ready=1) with mem_en=0, d_misalign=1 at G+1, and no d_rsp_valid.
REQ-020 Without MEM_MISALIGN_TRAP_EN, offending low address bits SHALL be cleared (half: bit0; word: bits[1:0]) before lane/enable generation, and d_misalign SHALL be tied 0.

Verification
REQ-021 Fetch 0x100 alone, mem_rdata=0xDEADBEEF -> f_req_ready=1, mem_addr=0x40, f_rsp_valid=1 next cycle, f_rsp_data=0xDEADBEEF.
REQ-022 SB addr 0x203, wdata 0x000000A5 -> mem_we=4'b1000, mem_wdata=0xA5A5A5A5, mem_addr=0x80, no response.
REQ-023 Fetch and data both valid for 5 cycles, STARVE_LIMIT=3 -> grants D,D,D,F,D.
REQ-024 LW 0x302 -> with MEM_MISALIGN_TRAP_EN: mem_en=0, d_misalign pulse at G+1; without: mem_addr=0xC0, d_rsp_valid at G+1.
REQ-025 Back-to-back data load then fetch -> d_rsp_valid at G+1, f_rsp_valid at G+2, never overlapping.
REQ-026 rst_n asserted in the cycle after a load grant -> d_rsp_valid stays 0, state IDLE after release.
